// File: rtl/pipe_pkg.sv
// Shared types and constants for the 3-bit-opcode pipeline.
package pipe_pkg;

    localparam int unsigned REG_AW = 3;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_SW  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_BEQ = 3'b110
    } opcode_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       beq;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the EX-stage load and the decode instruction.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic              ex_valid_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_dest_i,
    input  logic              id_valid_i,
    input  logic              id_mem_read_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    output logic              hz_o
);

    logic w_uses_rt;
    logic w_rs_match;
    logic w_rt_match;

    // A load writes rt rather than reading it; every other instruction reads rt.
    always_comb begin
        w_uses_rt  = ~id_mem_read_i;
        w_rs_match = (ex_dest_i == rs_i);
        w_rt_match = w_uses_rt & (ex_dest_i == rt_i);
        hz_o       = ex_valid_i & ex_mem_read_i & id_valid_i & (w_rs_match | w_rt_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush handling and bubble counter.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 8,
    parameter int unsigned CW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic [1:0]        alu_op_i,
    input  logic              beq_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              alu_src_i,
    input  logic              mem_to_reg_i,
    input  logic              reg_write_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [DW-1:0]     rs_data_i,
    input  logic [DW-1:0]     rt_data_i,
    input  logic [DW-1:0]     imm_i,
    input  logic [AW-1:0]     pc_i,
    input  logic              flush_i,
    output logic              ex_valid_o,
    output logic [1:0]        alu_op_o,
    output logic              beq_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              alu_src_o,
    output logic              mem_to_reg_o,
    output logic              reg_write_o,
    output logic [REG_AW-1:0] rs_o,
    output logic [REG_AW-1:0] rt_o,
    output logic [REG_AW-1:0] dest_o,
    output logic [DW-1:0]     rs_data_o,
    output logic [DW-1:0]     rt_data_o,
    output logic [DW-1:0]     imm_o,
    output logic [AW-1:0]     pc_o,
    output logic              stall_o,
    output logic [CW-1:0]     bubble_cnt_o
);

    logic              r_valid;
    ctrl_t             r_ctrl;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_dest;
    logic [DW-1:0]     r_rs_data;
    logic [DW-1:0]     r_rt_data;
    logic [DW-1:0]     r_imm;
    logic [AW-1:0]     r_pc;
    logic [CW-1:0]     r_bubble_cnt;

    logic              w_hz;
    logic              w_bubble;
    logic              w_count;
    ctrl_t             w_ctrl_in;
    logic [REG_AW-1:0] w_dest;

    hazard_detect u_hazard_detect (
        .ex_valid_i    (r_valid),
        .ex_mem_read_i (r_ctrl.mem_read),
        .ex_dest_i     (r_dest),
        .id_valid_i    (id_valid_i),
        .id_mem_read_i (mem_read_i),
        .rs_i          (rs_i),
        .rt_i          (rt_i),
        .hz_o          (w_hz)
    );

    // Capture-side decode: control gating, destination select, bubble/count decisions.
    always_comb begin
        w_ctrl_in = CTRL_BUBBLE;
        if (id_valid_i) begin
            w_ctrl_in = '{alu_op: alu_op_i, beq: beq_i, mem_read: mem_read_i,
                          mem_write: mem_write_i, alu_src: alu_src_i,
                          mem_to_reg: mem_to_reg_i, reg_write: reg_write_i};
        end
        w_dest   = alu_src_i ? rt_i : rd_i;
        w_bubble = flush_i | w_hz;
        // A flush only counts when it kills a real instruction; flush beats hazard.
        w_count  = flush_i ? id_valid_i : w_hz;
        stall_o  = w_hz & ~flush_i;
    end

    // Valid flag and control bundle: bubble on flush or hazard, else capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_BUBBLE;
        end else if (w_bubble) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_BUBBLE;
        end else begin
            r_valid <= id_valid_i;
            r_ctrl  <= w_ctrl_in;
        end
    end

    // Data, specifier and PC fields: held across bubbles, captured otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs      <= '0;
            r_rt      <= '0;
            r_dest    <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_pc      <= '0;
        end else if (!w_bubble) begin
            r_rs      <= rs_i;
            r_rt      <= rt_i;
            r_dest    <= w_dest;
            r_rs_data <= rs_data_i;
            r_rt_data <= rt_data_i;
            r_imm     <= imm_i;
            r_pc      <= pc_i;
        end
    end

    // Saturating bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_count && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign ex_valid_o   = r_valid;
    assign alu_op_o     = r_ctrl.alu_op;
    assign beq_o        = r_ctrl.beq;
    assign mem_read_o   = r_ctrl.mem_read;
    assign mem_write_o  = r_ctrl.mem_write;
    assign alu_src_o    = r_ctrl.alu_src;
    assign mem_to_reg_o = r_ctrl.mem_to_reg;
    assign reg_write_o  = r_ctrl.reg_write;
    assign rs_o         = r_rs;
    assign rt_o         = r_rt;
    assign dest_o       = r_dest;
    assign rs_data_o    = r_rs_data;
    assign rt_data_o    = r_rt_data;
    assign imm_o        = r_imm;
    assign pc_o         = r_pc;
    assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the 3-bit-opcode pipeline, sitting directly downstream of the decode-stage control unit. It captures the decoded control bundle, register operands, immediate and PC, and presents them to the execute stage one cycle later. It detects load-use hazards, inserts bubbles, and issues the stall to PC and IF/ID. It also honours branch flushes and keeps a saturating bubble counter for performance monitoring.

## Interface
Parameters:
- DW, 16, datapath width (operands, immediate)
- AW, 8, PC width
- CW, 16, bubble counter width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  decode stage holds a real instruction
- alu_op_i  in  2  ALU op from control unit (00 add, 01 sub, 10 and, 11 or)
- beq_i, mem_read_i, mem_write_i, alu_src_i, mem_to_reg_i, reg_write_i  in  1 each  control unit outputs
- rs_i, rt_i, rd_i  in  3 each  register specifiers of decode instruction
- rs_data_i, rt_data_i  in  DW each  register file read data
- imm_i  in  DW  sign-extended immediate
- pc_i  in  AW  PC of decode instruction
- flush_i  in  1  branch taken in later stage; kill decode instruction
- ex_valid_o  out  1  EX stage holds a real instruction
- alu_op_o, beq_o, mem_read_o, mem_write_o, alu_src_o, mem_to_reg_o, reg_write_o  out  2/1  registered control bundle
- rs_o, rt_o  out  3 each  registered specifiers (for forwarding)
- dest_o  out  3  registered destination register
- rs_data_o, rt_data_o, imm_o  out  DW each  registered data
- pc_o  out  AW  registered PC
- stall_o  out  1  combinational; hold PC and IF/ID this cycle
- bubble_cnt_o  out  CW  count of inserted bubbles, saturating

## Operation
- Destination select at capture: dest = rt_i if alu_src_i=1 (LW/SW), else rd_i. dest_o is meaningful only when reg_write_o=1.
- Operand use: decode instruction uses rs whenever id_valid_i=1. It uses rt unless mem_read_i=1 (LW writes rt; SW, ALU and BEQ all read it).
- Load-use hazard: hz = ex_valid_o & mem_read_o & id_valid_i & (dest_o==rs_i | (uses_rt & dest_o==rt_i)). Register 0 is not special.
- stall_o = hz & ~flush_i.
- Per-edge action, in priority order:
  1. flush_i=1: load a bubble. Increment bubble_cnt_o when id_valid_i=1.
  2. hz=1: load a bubble and increment bubble_cnt_o. Upstream holds its instruction and presents it again next cycle.
  3. Otherwise: capture all inputs, with ex_valid_o <= id_valid_i.
- Bubble definition: ex_valid_o=0 and all seven control outputs 0. Data, specifier and PC fields may hold any value; the bench does not check them.
- id_valid_i=0 is a plain load, not a bubble, and does not count. Its control outputs are forced to 0.
- A load-use stall lasts exactly one cycle. After the bubble, mem_read_o=0, so hz deasserts on its own.
- Undefined opcode 111 arrives as all-zero controls and passes through as a valid no-op.
- bubble_cnt_o saturates at 2^CW-1 and never wraps.

## Timing
- Reset (rst_n low, asynchronous): every registered output is 0, including ex_valid_o and bubble_cnt_o. stall_o evaluates to 0.
- Release is synchronous to the next rising clk edge. The first capture happens on the first edge with rst_n high.
- Latency: inputs appear on outputs 1 cycle after the capturing edge.
- stall_o is combinational from registered EX state plus the same-cycle ID inputs. Valid before the edge; no register on this path.
- flush_i and hz in the same cycle: flush wins and stall_o=0.
- Reset asserted mid-stall: all state clears immediately and the stalled instruction is discarded.

## Structure
- Package pipe_pkg:
  - opcode enum (LW=000, SW=001, ADD=010, SUB=011, AND=100, OR=101, BEQ=110)
  - alu_op constants
  - packed struct ctrl_t {alu_op, beq, mem_read, mem_write, alu_src, mem_to_reg, reg_write}
  - constant CTRL_BUBBLE = '0
  - REG_AW=3
- Sub-module hazard_detect: purely combinational, computes hz and uses_rt.
- Top level owns the registers and the counter.

## Test plan
- Reset: rst_n low mid-run → all outputs 0 immediately. After release, ADD r1,r2→r3 reaches outputs 1 cycle later with alu_op_o=00, reg_write_o=1, dest_o=3.
- Load-use: LW r5←[r2+4], then ADD r6=r5+r1 → stall_o=1 for exactly 1 cycle, one bubble (ex_valid_o=0), bubble_cnt_o=1. The ADD then appears with rs_o=5.
- No hazard: LW to r5, then SW reading r4 with base r2 → stall_o stays 0. Also LW to r5 then LW to r7 with base r3 → stall_o stays 0 (rt not used by LW).
- Flush vs hazard: a hazard condition with flush_i=1 in the same cycle → stall_o=0, bubble loaded, bubble_cnt_o increments by 1.
- Saturation: CW=2, force 5 bubbles → bubble_cnt_o stops at 3.
- Opcode 111 with id_valid_i=1 → ex_valid_o=1, all controls 0, no stall.
